udp_rx: RTL
===========

Name: udp_rx

Overview:
- GMII receive-side UDP/IPv4 parser; the counterpart of the board's UDP transmitter. Sits between the GMII RX pins (after any RGMII/DDR conversion) and the user receive FIFO.
- Strips the preamble/SFD, Ethernet header, IPv4 header and UDP header. Filters frames on MAC, EtherType, IP protocol and destination IP.
- Packs UDP payload bytes big-endian into 32-bit words and reports the payload byte count at end of packet.
- Does not check the FCS; frame integrity is handled downstream.

Parameters:
- BOARD_MAC, 48'h00_11_22_33_44_55, board MAC; frames accepted if destination MAC equals this or 48'hff_ff_ff_ff_ff_ff.
- BOARD_IP, {8'd192,8'd168,8'd1,8'd123}, board IPv4; frames accepted only if destination IP equals this.

Ports:
- clk  input  1  GMII RX clock (125 MHz); all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- gmii_rx_dv  input  1  GMII receive data valid.
- gmii_rxd  input  8  GMII receive data byte.
- rec_en  output  1  one-cycle strobe, rec_data valid.
- rec_data  output  32  payload word; first received byte in [31:24].
- rec_pkt_done  output  1  one-cycle strobe, accepted UDP packet fully received.
- rec_byte_num  output  16  UDP payload byte count (UDP length − 8); valid from the rec_pkt_done cycle until the next packet's done.

Behaviour:
- Reset: all outputs 0; state st_idle; all counters 0.
- States (one-hot):
  - st_idle
  - st_preamble
  - st_eth_head
  - st_ip_head
  - st_udp_head
  - st_rx_data
  - st_rx_end
- A byte is consumed only on cycles with gmii_rx_dv=1.
- st_idle:
  - dv=1 and rxd=8'h55 -> st_preamble; byte counter=1.
  - Anything else: stay in st_idle.
- st_preamble:
  - Expects six more 8'h55, then 8'hd5.
  - After the 8'hd5 -> st_eth_head.
  - Any other byte, or 8'hd5 before 7 total 0x55 -> st_rx_end.
- st_eth_head (14 bytes):
  - Bytes 0–5 are the destination MAC; check after byte 5 against BOARD_MAC or broadcast.
  - Bytes 12–13 must be 16'h0800.
  - Mismatch -> st_rx_end after the failing check.
  - Pass -> st_ip_head.
- st_ip_head:
  - Byte 0: version nibble must be 4. Low nibble IHL gives header length IHL*4 bytes (IHL<5 -> st_rx_end). Options are skipped.
  - Byte 9 must be 8'd17; else st_rx_end.
  - Bytes 16–19 are the destination IP; compared after byte 19; mismatch -> st_rx_end.
  - After byte IHL*4−1 -> st_udp_head.
- st_udp_head (8 bytes):
  - Bytes 4–5 are the UDP length, latched.
  - Payload count = udp_len − 8.
  - udp_len < 8 -> st_rx_end.
  - udp_len == 8 (empty payload) -> st_rx_end with a done pending.
  - Otherwise -> st_rx_data.
- st_rx_data:
  - Byte k is placed into word lane (k mod 4): lane 0 -> [31:24] … lane 3 -> [7:0].
  - rec_en pulses in the cycle after lane-3 byte is sampled.
  - On the last payload byte, rec_en pulses the next cycle even if the word is partial; unused low lanes = 0.
  - Then -> st_rx_end with a done pending.
  - Bytes beyond the payload (Ethernet pad to 46, FCS) are ignored.
- st_rx_end:
  - Waits for dv=0, then -> st_idle.
  - On that transition, if a done is pending: rec_pkt_done=1 for one cycle, and rec_byte_num updated in the same cycle.
  - Filtered or aborted frames produce no rec_pkt_done and no rec_en.
- dv dropping in any state other than st_idle/st_rx_end:
  - Abort -> st_idle next cycle.
  - No rec_pkt_done.
  - Any partial word already collected is discarded; words already strobed stand.
- Back-to-back frames: a new frame is recognised starting the cycle after st_rx_end returns to st_idle; the minimum 12-byte IFG guarantees this.
- rst asserted mid-frame: next cycle returns to the reset state; the rest of the frame is discarded until dv=0 followed by a fresh preamble.
- rec_data holds its last value between strobes; consumers sample only on rec_en.
- Counters are 16 bits; payloads up to 1472 bytes are supported, no wrap within a frame.

Test Plan:
- 7×55, d5, MAC 00_11_22_33_44_55, type 0800, IHL 5, proto 17, dst IP 192.168.1.123, UDP len 16, payload 01..08 -> rec_en twice: 32'h01020304, 32'h05060708; rec_pkt_done=1 with rec_byte_num=8.
- Same frame, UDP len 13, payload 01..05 plus pad to 46 bytes -> words 01020304 and 05000000; rec_byte_num=5; pad and FCS produce no strobes.
- Broadcast destination MAC accepted. Destination MAC 00_11_22_33_44_56 -> no rec_en, no done. Destination IP 192.168.1.124, or proto 6 -> no rec_en, no done.
- Drop dv after 3 payload bytes -> no rec_en for the partial word, no done. A following valid frame is received correctly.
- IHL=6 with 4 option bytes, payload AA BB CC DD -> single word 32'hAABBCCDD, rec_byte_num=4.
- Assert rst during the IP header for 1 cycle -> outputs 0, no done. Next valid frame after dv low is received normally.

Source files
------------

// File: rtl/udp_rx.sv
// rtl/udp_rx.sv - GMII receive-side UDP/IPv4 parser packing payload into 32-bit words
module udp_rx #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd123}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        rec_en,
    output logic [31:0] rec_data,
    output logic        rec_pkt_done,
    output logic [15:0] rec_byte_num
);

    // One-hot state encoding
    localparam logic [6:0] ST_IDLE     = 7'b000_0001;
    localparam logic [6:0] ST_PREAMBLE = 7'b000_0010;
    localparam logic [6:0] ST_ETH_HEAD = 7'b000_0100;
    localparam logic [6:0] ST_IP_HEAD  = 7'b000_1000;
    localparam logic [6:0] ST_UDP_HEAD = 7'b001_0000;
    localparam logic [6:0] ST_RX_DATA  = 7'b010_0000;
    localparam logic [6:0] ST_RX_END   = 7'b100_0000;

    logic [6:0]  r_state;
    logic [6:0]  w_next_state;

    logic [15:0] r_cnt;         // byte index within the current header/payload section
    logic [39:0] r_mac_sr;      // first five destination MAC bytes
    logic [7:0]  r_type_hi;
    logic [3:0]  r_ihl;
    logic [23:0] r_ip_sr;       // first three destination IP bytes
    logic [7:0]  r_len_hi;
    logic [15:0] r_udp_len;
    logic [15:0] r_data_num;    // payload bytes expected (udp_len - 8)
    logic [31:0] r_word;        // word being assembled
    logic        r_done_pend;   // accepted packet awaiting end of frame
    logic        r_armed;       // a dv-low gap has been seen since reset

    logic        w_mac_ok;
    logic        w_type_ok;
    logic        w_ver_ok;
    logic        w_proto_ok;
    logic        w_ip_ok;
    logic        w_ip_last;
    logic        w_pay_last;
    logic [1:0]  w_lane;
    logic [31:0] w_word_next;

    // Field checks and word-lane insertion decoded from the current byte
    always_comb begin
        w_mac_ok    = ({r_mac_sr, gmii_rxd} == BOARD_MAC) ||
                      ({r_mac_sr, gmii_rxd} == 48'hff_ff_ff_ff_ff_ff);
        w_type_ok   = ({r_type_hi, gmii_rxd} == 16'h0800);
        w_ver_ok    = (gmii_rxd[7:4] == 4'd4) && (gmii_rxd[3:0] >= 4'd5);
        w_proto_ok  = (gmii_rxd == 8'd17);
        w_ip_ok     = ({r_ip_sr, gmii_rxd} == BOARD_IP);
        w_ip_last   = (r_cnt == ({10'd0, r_ihl, 2'b00} - 16'd1));
        w_pay_last  = (r_cnt == (r_data_num - 16'd1));
        w_lane      = r_cnt[1:0];
        w_word_next = r_word;
        case (w_lane)
            2'd0:    w_word_next = {gmii_rxd, 24'd0};
            2'd1:    w_word_next = {r_word[31:24], gmii_rxd, 16'd0};
            2'd2:    w_word_next = {r_word[31:16], gmii_rxd, 8'd0};
            default: w_word_next = {r_word[31:8], gmii_rxd};
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; dv low mid-frame aborts straight back to idle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (gmii_rx_dv && r_armed && (gmii_rxd == 8'h55)) begin
                    w_next_state = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    w_next_state = ST_IDLE;
                end else if ((gmii_rxd == 8'h55) && (r_cnt < 16'd7)) begin
                    w_next_state = ST_PREAMBLE;
                end else if ((gmii_rxd == 8'hd5) && (r_cnt == 16'd7)) begin
                    w_next_state = ST_ETH_HEAD;
                end else begin
                    w_next_state = ST_RX_END;
                end
            end
            ST_ETH_HEAD: begin
                if (!gmii_rx_dv) begin
                    w_next_state = ST_IDLE;
                end else if ((r_cnt == 16'd5) && !w_mac_ok) begin
                    w_next_state = ST_RX_END;
                end else if (r_cnt == 16'd13) begin
                    w_next_state = w_type_ok ? ST_IP_HEAD : ST_RX_END;
                end
            end
            ST_IP_HEAD: begin
                if (!gmii_rx_dv) begin
                    w_next_state = ST_IDLE;
                end else if ((r_cnt == 16'd0) && !w_ver_ok) begin
                    w_next_state = ST_RX_END;
                end else if ((r_cnt == 16'd9) && !w_proto_ok) begin
                    w_next_state = ST_RX_END;
                end else if ((r_cnt == 16'd19) && !w_ip_ok) begin
                    w_next_state = ST_RX_END;
                end else if ((r_cnt >= 16'd19) && w_ip_last) begin
                    w_next_state = ST_UDP_HEAD;
                end
            end
            ST_UDP_HEAD: begin
                if (!gmii_rx_dv) begin
                    w_next_state = ST_IDLE;
                end else if (r_cnt == 16'd7) begin
                    w_next_state = (r_udp_len <= 16'd8) ? ST_RX_END : ST_RX_DATA;
                end
            end
            ST_RX_DATA: begin
                if (!gmii_rx_dv) begin
                    w_next_state = ST_IDLE;
                end else if (w_pay_last) begin
                    w_next_state = ST_RX_END;
                end
            end
            ST_RX_END: begin
                if (!gmii_rx_dv) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Byte counter, header field capture, word packing and output strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= 16'd0;
            r_mac_sr     <= 40'd0;
            r_type_hi    <= 8'd0;
            r_ihl        <= 4'd0;
            r_ip_sr      <= 24'd0;
            r_len_hi     <= 8'd0;
            r_udp_len    <= 16'd0;
            r_data_num   <= 16'd0;
            r_word       <= 32'd0;
            r_done_pend  <= 1'b0;
            r_armed      <= 1'b0;
            rec_en       <= 1'b0;
            rec_data     <= 32'd0;
            rec_pkt_done <= 1'b0;
            rec_byte_num <= 16'd0;
        end else begin
            rec_en       <= 1'b0;
            rec_pkt_done <= 1'b0;

            // Leftover bytes of a frame cut by reset must not resync the parser
            if (!gmii_rx_dv) begin
                r_armed <= 1'b1;
            end

            if (!gmii_rx_dv) begin
                r_cnt <= 16'd0;
            end else if (r_state == ST_IDLE) begin
                r_cnt <= (w_next_state == ST_PREAMBLE) ? 16'd1 : 16'd0;
            end else if ((w_next_state != r_state) || (r_state == ST_RX_END)) begin
                r_cnt <= 16'd0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_done_pend <= 1'b0;
                end
                ST_ETH_HEAD: begin
                    if (gmii_rx_dv) begin
                        if (r_cnt < 16'd5)   r_mac_sr  <= {r_mac_sr[31:0], gmii_rxd};
                        if (r_cnt == 16'd12) r_type_hi <= gmii_rxd;
                    end
                end
                ST_IP_HEAD: begin
                    if (gmii_rx_dv) begin
                        if (r_cnt == 16'd0) r_ihl <= gmii_rxd[3:0];
                        if ((r_cnt >= 16'd16) && (r_cnt <= 16'd18)) begin
                            r_ip_sr <= {r_ip_sr[15:0], gmii_rxd};
                        end
                    end
                end
                ST_UDP_HEAD: begin
                    if (gmii_rx_dv) begin
                        if (r_cnt == 16'd4) r_len_hi <= gmii_rxd;
                        if (r_cnt == 16'd5) begin
                            r_udp_len  <= {r_len_hi, gmii_rxd};
                            r_data_num <= {r_len_hi, gmii_rxd} - 16'd8;
                        end
                        if ((r_cnt == 16'd7) && (r_udp_len == 16'd8)) begin
                            r_done_pend <= 1'b1;
                        end
                    end
                end
                ST_RX_DATA: begin
                    if (gmii_rx_dv) begin
                        r_word <= w_word_next;
                        if ((w_lane == 2'd3) || w_pay_last) begin
                            rec_en   <= 1'b1;
                            rec_data <= w_word_next;
                        end
                        if (w_pay_last) begin
                            r_done_pend <= 1'b1;
                        end
                    end
                end
                ST_RX_END: begin
                    if (!gmii_rx_dv && r_done_pend) begin
                        rec_pkt_done <= 1'b1;
                        rec_byte_num <= r_data_num;
                        r_done_pend  <= 1'b0;
                    end
                end
                default: begin
                    r_done_pend <= r_done_pend;
                end
            endcase
        end
    end

endmodule
